// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between N requesters,
// with optional burst hold of up to MAX_BURST bytes per grant.
module uart_tx_arbiter #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int HOLD      = 1,
  parameter int MAX_BURST = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           tx_start,
  output logic [W-1:0]   tx_data,
  input  logic           tx_ready
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, SEND, GUARD, WAIT} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [CW-1:0] burst_cnt;

  logic [PW-1:0] next_after_owner;
  logic [PW-1:0] scan_base;
  logic [PW-1:0] scan_idx;
  logic [PW-1:0] pick_idx;
  logic          pick_valid;
  logic          continue_burst;

  assign next_after_owner = (int'(owner) == N - 1) ? '0 : owner + 1'b1;
  assign continue_burst   = (HOLD != 0) && req[owner] && (burst_cnt < CW'(MAX_BURST));
  assign busy             = |grant;

  // Scanning upward from owner+1 puts the current owner last, so it only wins
  // when nobody else is requesting.
  always_comb begin
    scan_base  = (state == WAIT) ? next_after_owner : ptr;
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      scan_idx = PW'((int'(scan_base) + k) % N);
      if (req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      ack       <= '0;
      grant     <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
    end else begin
      tx_start <= 1'b0;
      ack      <= '0;
      case (state)
        IDLE: begin
          grant <= '0;
          if (tx_ready && pick_valid) begin
            owner     <= pick_idx;
            grant     <= N'(1) << pick_idx;
            ack       <= N'(1) << pick_idx;
            tx_start  <= 1'b1;
            tx_data   <= data[pick_idx*W +: W];
            burst_cnt <= CW'(1);
            state     <= SEND;
          end
        end
        SEND:  state <= GUARD;
        // The transmitter may still show ready here, so it is not sampled.
        GUARD: state <= WAIT;
        WAIT: begin
          if (tx_ready) begin
            if (continue_burst) begin
              ack       <= N'(1) << owner;
              tx_start  <= 1'b1;
              tx_data   <= data[owner*W +: W];
              burst_cnt <= burst_cnt + 1'b1;
              state     <= SEND;
            end else begin
              ptr <= next_after_owner;
              if (pick_valid) begin
                owner     <= pick_idx;
                grant     <= N'(1) << pick_idx;
                ack       <= N'(1) << pick_idx;
                tx_start  <= 1'b1;
                tx_data   <= data[pick_idx*W +: W];
                burst_cnt <= CW'(1);
                state     <= SEND;
              end else begin
                grant <= '0;
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
